// File: rtl/multi_link_ctrl.sv
// Board-to-board link controller: synchronised, glitch-filtered rx lines feeding a
// connect/start/finish FSM with connect timeout, link-loss detection and finish arbitration.
module multi_link_ctrl #(
  parameter int N_PEERS        = 1,
  parameter int SYNC_STAGES    = 2,
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 100000000,
  localparam int ID_W          = (N_PEERS > 1) ? $clog2(N_PEERS) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               role,
  input  logic               req_connect,
  input  logic               req_start,
  input  logic               req_return,
  input  logic               local_finish,
  input  logic [N_PEERS-1:0] rx_connect,
  input  logic [N_PEERS-1:0] rx_start,
  input  logic [N_PEERS-1:0] rx_finish,
  output logic               tx_connect,
  output logic               tx_start,
  output logic               tx_finish,
  output logic [2:0]         state,
  output logic [N_PEERS-1:0] connected_mask,
  output logic               all_connected,
  output logic               game_init,
  output logic [ID_W-1:0]    finish_peer_id,
  output logic               timeout,
  output logic               link_lost
);

  localparam int NB    = 3 * N_PEERS;
  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_HIT = (TIMEOUT_CYCLES == 0) ? '0 : TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CONNECT = 3'd1,
    S_PLAY    = 3'd2,
    S_WIN     = 3'd3,
    S_LOSE    = 3'd4
  } state_t;

  logic [NB-1:0]    raw;
  logic [NB-1:0]    sync_q [SYNC_STAGES];
  logic [NB-1:0]    synced;
  logic [NB-1:0]    filt_q;
  logic [CNT_W-1:0] stab_q [NB];
  logic [N_PEERS-1:0] conn_f, start_f, fin_f;
  logic             unused_start;

  assign raw    = {rx_finish, rx_start, rx_connect};
  assign synced = sync_q[SYNC_STAGES-1];
  assign conn_f  = filt_q[N_PEERS-1:0];
  assign start_f = filt_q[2*N_PEERS-1:N_PEERS];
  assign fin_f   = filt_q[3*N_PEERS-1:2*N_PEERS];
  // Only the master's start line (peer 0) is acted on; the rest are filtered but unread.
  assign unused_start = ^start_f;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= raw;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Counter tracks how long the synced bit has disagreed with the filtered value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= '0;
      for (int b = 0; b < NB; b++) stab_q[b] <= '0;
    end else begin
      for (int b = 0; b < NB; b++) begin
        if (synced[b] == filt_q[b]) begin
          stab_q[b] <= '0;
        end else if (stab_q[b] == STAB_LAST) begin
          filt_q[b] <= synced[b];
          stab_q[b] <= '0;
        end else begin
          stab_q[b] <= stab_q[b] + CNT_W'(1);
        end
      end
    end
  end

  assign connected_mask = conn_f;
  assign all_connected  = &conn_f;

  state_t          st_q, st_d;
  logic            role_q;
  logic [TO_W-1:0] to_cnt_q;
  logic            to_hit, lost_hit;
  logic [ID_W-1:0] fin_idx;

  assign state = st_q;

  always_comb begin
    fin_idx = '0;
    for (int i = N_PEERS - 1; i >= 0; i--) begin
      if (fin_f[i]) fin_idx = ID_W'(i);
    end
  end

  always_comb begin
    st_d     = st_q;
    to_hit   = 1'b0;
    lost_hit = 1'b0;
    case (st_q)
      S_IDLE: begin
        if (!req_return && req_connect) st_d = S_CONNECT;
      end
      S_CONNECT: begin
        if (req_return) begin
          st_d = S_IDLE;
        end else if (TIMEOUT_CYCLES != 0 && !all_connected && to_cnt_q == TO_HIT) begin
          st_d   = S_IDLE;
          to_hit = 1'b1;
        end else if (all_connected && (role_q ? start_f[0] : req_start)) begin
          st_d = S_PLAY;
        end
      end
      S_PLAY: begin
        if (req_return) begin
          st_d = S_IDLE;
        end else if (!all_connected) begin
          st_d     = S_IDLE;
          lost_hit = 1'b1;
        end else if (local_finish) begin
          st_d = S_WIN;
        end else if (|fin_f) begin
          st_d = S_LOSE;
        end
      end
      S_WIN, S_LOSE: begin
        if (req_return) st_d = S_IDLE;
      end
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q           <= S_IDLE;
      role_q         <= 1'b0;
      to_cnt_q       <= '0;
      tx_connect     <= 1'b0;
      tx_start       <= 1'b0;
      tx_finish      <= 1'b0;
      game_init      <= 1'b0;
      timeout        <= 1'b0;
      link_lost      <= 1'b0;
      finish_peer_id <= '0;
    end else begin
      st_q <= st_d;
      if (st_q == S_IDLE) role_q <= role;
      if (st_q != S_CONNECT || all_connected) begin
        to_cnt_q <= '0;
      end else if (to_cnt_q != TO_MAX) begin
        to_cnt_q <= to_cnt_q + TO_W'(1);
      end
      tx_connect <= (st_d != S_IDLE);
      tx_start   <= (st_d == S_PLAY);
      tx_finish  <= (st_d == S_WIN);
      game_init  <= (st_d == S_PLAY) && (st_q != S_PLAY);
      timeout    <= to_hit;
      link_lost  <= lost_hit;
      if (st_d == S_LOSE && st_q != S_LOSE) finish_peer_id <= fin_idx;
    end
  end

endmodule

// File: tb/tb_multi_link_ctrl.sv
// Bench for multi_link_ctrl: table-driven flows, hand-written corner sequences and a
// randomized run, all cross-checked every cycle against a window-based reference model.
module tb_multi_link_ctrl;
  localparam int N  = 3;
  localparam int SS = 2;
  localparam int SC = 4;
  localparam int TO = 50;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic role = 1'b0, req_connect = 1'b0, req_start = 1'b0, req_return = 1'b0;
  logic local_finish = 1'b0;
  logic [N-1:0] rx_connect = '0, rx_start = '0, rx_finish = '0;
  logic tx_connect, tx_start, tx_finish;
  logic [2:0] state;
  logic [N-1:0] connected_mask;
  logic all_connected, game_init, timeout, link_lost;
  logic [1:0] finish_peer_id;

  int checks = 0;
  int errors = 0;

  multi_link_ctrl #(
    .N_PEERS(N), .SYNC_STAGES(SS), .STABLE_CYCLES(SC), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .role(role), .req_connect(req_connect),
    .req_start(req_start), .req_return(req_return), .local_finish(local_finish),
    .rx_connect(rx_connect), .rx_start(rx_start), .rx_finish(rx_finish),
    .tx_connect(tx_connect), .tx_start(tx_start), .tx_finish(tx_finish),
    .state(state), .connected_mask(connected_mask), .all_connected(all_connected),
    .game_init(game_init), .finish_peer_id(finish_peer_id), .timeout(timeout),
    .link_lost(link_lost)
  );

  always #5 clk = ~clk;

  // Reference model: states 0..4, filtered lines derived from a window of raw samples.
  int m_st, m_tcnt, m_fid;
  bit m_role, m_gi, m_to, m_ll;
  logic [2:0] m_tx;
  logic [N-1:0] m_conn, m_start, m_fin;
  logic [3*N-1:0] hist [$];

  task automatic model_reset();
    m_st = 0; m_tcnt = 0; m_fid = 0; m_role = 0;
    m_gi = 0; m_to = 0; m_ll = 0; m_tx = '0;
    m_conn = '0; m_start = '0; m_fin = '0;
    hist.delete();
    for (int i = 0; i < SS + SC; i++) hist.push_back('0);
  endtask

  task automatic model_step();
    int ns;
    bit ac, all1, all0;
    logic [3*N-1:0] filt;
    ns = m_st;
    ac = &m_conn;
    m_gi = 0; m_to = 0; m_ll = 0;
    case (m_st)
      0: begin
        m_role = role;
        if (!req_return && req_connect) ns = 1;
      end
      1: begin
        if (req_return) ns = 0;
        else if (!ac && m_tcnt == TO - 1) begin ns = 0; m_to = 1; end
        else if (ac && (m_role ? m_start[0] : req_start)) ns = 2;
      end
      2: begin
        if (req_return) ns = 0;
        else if (!ac) begin ns = 0; m_ll = 1; end
        else if (local_finish) ns = 3;
        else if (m_fin != 0) begin
          ns = 4;
          for (int i = 0; i < N; i++) if (m_fin[i]) begin m_fid = i; break; end
        end
      end
      default: if (req_return) ns = 0;
    endcase
    // Consecutive unconnected CONNECT cycles seen so far.
    m_tcnt = (m_st == 1 && !ac) ? m_tcnt + 1 : 0;
    m_gi = (ns == 2 && m_st != 2);
    m_tx = {ns == 3, ns == 2, ns != 0};
    m_st = ns;
    // A line takes value v once the last SC delayed samples all equal v.
    hist.push_back({rx_finish, rx_start, rx_connect});
    filt = {m_fin, m_start, m_conn};
    for (int b = 0; b < 3 * N; b++) begin
      all1 = 1; all0 = 1;
      for (int j = 1; j <= SC; j++) begin
        if (!hist[j][b]) all1 = 0;
        if (hist[j][b]) all0 = 0;
      end
      if (all1) filt[b] = 1'b1;
      if (all0) filt[b] = 1'b0;
    end
    void'(hist.pop_front());
    {m_fin, m_start, m_conn} = filt;
  endtask

  task automatic cmp_model();
    logic [14:0] act, exp;
    act = {state, tx_finish, tx_start, tx_connect, connected_mask, all_connected,
           game_init, timeout, link_lost, finish_peer_id};
    exp = {3'(m_st), m_tx, m_conn, &m_conn, m_gi, m_to, m_ll, 2'(m_fid)};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL model t=%0t: got %h expected %h", $time, act, exp);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cmp_model();
  endtask

  typedef struct {
    int ncyc;
    bit rl, rc, rs, rr;
    logic [N-1:0] rxc, rxs, rxf;
    logic [2:0] st, tx;
    logic [N-1:0] mask;
    logic [1:0] fid;
    bit gi;
  } vec_t;

  vec_t tbl [10];

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not complete at t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, gi_cnt;
    logic bad;
    //        ncyc rl rc rs rr  rxc     rxs     rxf     st    tx{f,s,c} mask   fid  gi
    tbl[0] = '{8, 0, 1, 0, 0, 3'b011, 3'b000, 3'b000, 3'd1, 3'b001, 3'b011, 2'd0, 0};
    tbl[1] = '{2, 0, 0, 1, 0, 3'b011, 3'b000, 3'b000, 3'd1, 3'b001, 3'b011, 2'd0, 0};
    tbl[2] = '{8, 0, 0, 0, 0, 3'b111, 3'b000, 3'b000, 3'd1, 3'b001, 3'b111, 2'd0, 0};
    tbl[3] = '{1, 0, 0, 1, 0, 3'b111, 3'b000, 3'b000, 3'd2, 3'b011, 3'b111, 2'd0, 1};
    tbl[4] = '{8, 0, 0, 0, 0, 3'b111, 3'b000, 3'b110, 3'd4, 3'b001, 3'b111, 2'd1, 0};
    tbl[5] = '{1, 0, 0, 0, 1, 3'b111, 3'b000, 3'b000, 3'd0, 3'b000, 3'b111, 2'd1, 0};
    tbl[6] = '{8, 1, 1, 0, 0, 3'b111, 3'b000, 3'b000, 3'd1, 3'b001, 3'b111, 2'd1, 0};
    tbl[7] = '{8, 1, 0, 0, 0, 3'b111, 3'b010, 3'b000, 3'd1, 3'b001, 3'b111, 2'd1, 0};
    tbl[8] = '{8, 1, 0, 0, 0, 3'b111, 3'b011, 3'b000, 3'd2, 3'b011, 3'b111, 2'd1, 0};
    tbl[9] = '{1, 1, 0, 0, 1, 3'b111, 3'b000, 3'b000, 3'd0, 3'b000, 3'b111, 2'd1, 0};

    model_reset();
    repeat (3) @(negedge clk);
    chk("reset outputs", 32'({state, tx_finish, tx_start, tx_connect, connected_mask,
        all_connected, game_init, timeout, link_lost, finish_peer_id}), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      role = tbl[i].rl; req_connect = tbl[i].rc; req_start = tbl[i].rs;
      req_return = tbl[i].rr; rx_connect = tbl[i].rxc; rx_start = tbl[i].rxs;
      rx_finish = tbl[i].rxf;
      for (int c = 0; c < tbl[i].ncyc; c++) begin
        tick();
        req_connect = 0; req_start = 0; req_return = 0;
      end
      chk($sformatf("vec%0d state", i), 32'(state), 32'(tbl[i].st));
      chk($sformatf("vec%0d tx", i), 32'({tx_finish, tx_start, tx_connect}), 32'(tbl[i].tx));
      chk($sformatf("vec%0d mask", i), 32'(connected_mask), 32'(tbl[i].mask));
      chk($sformatf("vec%0d fid", i), 32'(finish_peer_id), 32'(tbl[i].fid));
      chk($sformatf("vec%0d game_init", i), 32'(game_init), 32'(tbl[i].gi));
    end

    // Glitch rejection and filter latency on rx_connect[1].
    role = 0; rx_connect = '0; rx_start = '0; rx_finish = '0;
    repeat (10) tick();
    chk("mask cleared", 32'(connected_mask), 32'd0);
    rx_connect = 3'b010;
    repeat (3) tick();
    rx_connect = 3'b000;
    bad = 0;
    repeat (10) begin tick(); if (connected_mask !== 3'b000) bad = 1; end
    chk("glitch blocked", 32'(bad), 32'd0);
    rx_connect = 3'b010;
    n = 0;
    while (n < 20 && connected_mask[1] !== 1'b1) begin tick(); n++; end
    chk("filter latency", n, 6);

    // Master flow: game_init is a single-cycle pulse.
    rx_connect = 3'b111;
    repeat (8) tick();
    req_connect = 1; tick(); req_connect = 0;
    chk("master connect state", 32'(state), 32'd1);
    req_start = 1; tick(); req_start = 0;
    chk("master play state", 32'(state), 32'd2);
    chk("master tx_start", 32'(tx_start), 32'd1);
    chk("game_init first cycle", 32'(game_init), 32'd1);
    gi_cnt = 0;
    repeat (4) begin tick(); gi_cnt += int'(game_init); end
    chk("game_init width", gi_cnt, 0);

    // Link loss in PLAY.
    rx_connect = 3'b110;
    n = 0;
    while (n < 20 && state == 3'd2) begin tick(); n++; end
    chk("link loss cycles", n, 7);
    chk("link_lost pulse", 32'(link_lost), 32'd1);
    chk("link loss state", 32'(state), 32'd0);

    // Connect timeout with only peer 0 connected.
    rx_connect = 3'b001;
    repeat (8) tick();
    req_connect = 1; tick(); req_connect = 0;
    chk("timeout connect state", 32'(state), 32'd1);
    n = 0;
    while (n < 100 && timeout !== 1'b1) begin tick(); n++; end
    chk("timeout cycles", n, TO);
    chk("timeout state", 32'(state), 32'd0);
    chk("timeout tx_connect", 32'(tx_connect), 32'd0);
    tick();
    chk("timeout pulse width", 32'(timeout), 32'd0);

    // Local finish coincident with filtered rx_finish[0] wins.
    rx_connect = 3'b111;
    repeat (8) tick();
    req_connect = 1; tick(); req_connect = 0;
    req_start = 1; tick(); req_start = 0;
    chk("arb play state", 32'(state), 32'd2);
    rx_finish = 3'b001;
    repeat (6) tick();
    chk("arb still play", 32'(state), 32'd2);
    local_finish = 1;
    tick();
    chk("arb win state", 32'(state), 32'd3);
    chk("arb tx_finish", 32'(tx_finish), 32'd1);

    // Asynchronous reset while in WIN.
    #2 rst_n = 1'b0;
    #1;
    chk("async reset outputs", 32'({state, tx_finish, tx_start, tx_connect, connected_mask,
        all_connected, game_init, timeout, link_lost, finish_peer_id}), 32'd0);
    model_reset();
    local_finish = 0; rx_finish = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized run against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) role = ~role;
      req_connect = ($urandom_range(0, 9) == 0);
      req_start   = ($urandom_range(0, 9) == 0);
      req_return  = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 49) == 0) local_finish = ~local_finish;
      for (int b = 0; b < N; b++) begin
        if (rx_connect[b] ? ($urandom_range(0, 119) == 0) : ($urandom_range(0, 9) == 0))
          rx_connect[b] = ~rx_connect[b];
        if ($urandom_range(0, 29) == 0) rx_start[b] = ~rx_start[b];
        if (rx_finish[b] ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 149) == 0))
          rx_finish[b] = ~rx_finish[b];
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_link_ctrl.md
Name: multi_link_ctrl

Overview:
- Parametrised successor to the single-wire two-board connect/start/finish link used by the stage controller.
- Supports N_PEERS remote boards, with a synchroniser and glitch filter per line, connect timeout, link-loss detection and finish arbitration.
- Sits between the board-to-board pmod wires and the game-stage logic.
- Drives game_init and the win/lose result shown by the VGA block.

Parameters:
- N_PEERS, 1: number of remote boards; peer 0 is the master when role=1.
- SYNC_STAGES, 2: flops per rx line in the synchroniser chain (minimum 2).
- STABLE_CYCLES, 16: consecutive equal synced samples required before the filtered value updates (minimum 1).
- TIMEOUT_CYCLES, 100000000: cycles allowed in CONNECT before giving up; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- role  in  1  0 = master, 1 = slave; sampled only in IDLE
- req_connect  in  1  one-cycle pulse (connect button click)
- req_start  in  1  one-cycle pulse (start button click; honoured only when master)
- req_return  in  1  one-cycle pulse (return button click)
- local_finish  in  1  level; local board solved
- rx_connect  in  N_PEERS  asynchronous connect line from each peer
- rx_start  in  N_PEERS  asynchronous start line from each peer
- rx_finish  in  N_PEERS  asynchronous finish line from each peer
- tx_connect  out  1  connect line to peers
- tx_start  out  1  start line to peers
- tx_finish  out  1  finish line to peers
- state  out  3  0 IDLE, 1 CONNECT, 2 PLAY, 3 WIN, 4 LOSE
- connected_mask  out  N_PEERS  filtered rx_connect
- all_connected  out  1  AND of connected_mask
- game_init  out  1  one-cycle pulse on PLAY entry
- finish_peer_id  out  max(1,$clog2(N_PEERS))  lowest-index peer that finished first; valid in LOSE
- timeout  out  1  one-cycle pulse on connect timeout
- link_lost  out  1  one-cycle pulse on peer drop during PLAY

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0, state IDLE.
  - Sync chains and filter values 0; all counters 0.
  - Reset mid-game aborts immediately; no finish is transmitted.
- Input filtering:
  - Each rx bit passes SYNC_STAGES flops, then a per-bit stability counter.
  - The filtered bit takes the synced value after STABLE_CYCLES consecutive equal samples that differ from the current filtered value.
  - Raw edge to filtered edge = SYNC_STAGES+STABLE_CYCLES cycles (±1 for metastability).
  - A pulse shorter than STABLE_CYCLES never propagates.
- Outputs are registered; tx lines change on the cycle after the state transition.
- Priority inside any state: req_return > link loss > finish > start/connect.
- IDLE:
  - Drives tx_* = 0.
  - Latches role.
  - req_connect → CONNECT and clears the timeout counter.
- CONNECT:
  - Drives tx_connect=1.
  - Timeout counter increments every cycle while !all_connected; it is held at 0 while all_connected.
  - Counter reaching TIMEOUT_CYCLES → IDLE with a one-cycle timeout pulse.
  - Master: all_connected && req_start → PLAY.
  - Slave: all_connected && filtered rx_start[0] → PLAY.
  - req_start ignored when slave or when !all_connected.
- PLAY:
  - Drives tx_connect=1 and tx_start=1 (slave also drives tx_start=1 as acknowledge).
  - game_init=1 exactly on the first PLAY cycle.
  - Any connected_mask bit falling → IDLE with a one-cycle link_lost pulse.
  - local_finish high → WIN.
  - Else any filtered rx_finish → LOSE, and finish_peer_id latches the lowest set index.
  - local_finish and rx_finish in the same cycle → WIN (local priority).
- WIN: drives tx_connect=1, tx_finish=1; holds until req_return.
- LOSE: drives tx_connect=1, tx_finish=0; holds until req_return.
- In WIN/LOSE, peer drop and rx changes are ignored.
- req_return → IDLE from any state; the IDLE→IDLE transition has no other effect.
- Counters saturate and never wrap.
- finish_peer_id is held until the next LOSE entry and cleared on reset only.

Test Plan:
- Filter: N_PEERS=2, STABLE_CYCLES=4, SYNC_STAGES=2.
  - 3-cycle rx_connect[1] glitch → connected_mask stays 00.
  - rx_connect[1] held high → connected_mask[1] rises 6 cycles later (±1).
- Master flow, N_PEERS=2, role=0:
  - Stimulus: req_connect, both rx_connect high, req_start.
  - Required: state 0→1→2; game_init high exactly 1 cycle; tx_start=1.
  - req_start before all_connected → state stays 1.
- Slave flow, role=1:
  - Stimulus: connect, then rx_start[0] high.
  - Required: PLAY entry after filter latency; rx_start[1] alone does not start.
- Timeout: TIMEOUT_CYCLES=50, only one of two peers connected.
  - Required: timeout pulse at cycle 50 after CONNECT entry; state→0; tx_connect→0.
- Finish arbitration, N_PEERS=3, in PLAY:
  - rx_finish=110 → LOSE, finish_peer_id=1.
  - Separate run: local_finish coincident with filtered rx_finish[0] → WIN, tx_finish=1.
- Link loss and reset:
  - rx_connect[0] dropped in PLAY → link_lost pulse, state 0.
  - rst_n asserted mid-WIN → all outputs 0 asynchronously.
